// File: rtl/decoder_scan_nbit_if.sv
// Bus bundle for decoder_scan_nbit: control/select inputs and registered strobe outputs.
// The master side drives en/mode/a/load; the slave (the decoder) drives y/idx/wrap.
interface decoder_scan_nbit_if #(
    parameter int unsigned N = 2
);
    localparam int unsigned W = 1 << N;

    logic         en;
    logic         mode;
    logic [N-1:0] a;
    logic         load;
    logic [W-1:0] y;
    logic [N-1:0] idx;
    logic         wrap;

    modport master (
        output en,
        output mode,
        output a,
        output load,
        input  y,
        input  idx,
        input  wrap
    );

    modport slave (
        input  en,
        input  mode,
        input  a,
        input  load,
        output y,
        output idx,
        output wrap
    );
endinterface

// File: rtl/decoder_scan_nbit.sv
// Registered N-to-2^N one-hot decoder with direct and auto-scan modes.
// Direct mode decodes a; scan mode steps the active line every SCAN_DIV enabled cycles.
// Optional macro DECODER_SCAN_ACTIVE_LOW_EN: y is driven inverted (active line low,
// blank/reset value all-ones). idx and wrap are unaffected.
module decoder_scan_nbit #(
    parameter int unsigned N        = 2,
    parameter int unsigned SCAN_DIV = 4
) (
    input logic                  clk,
    input logic                  rst,
    decoder_scan_nbit_if.slave   bus
);
    localparam int unsigned W  = 1 << N;
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PcntLast = PW'(SCAN_DIV - 1);

    // Registered mode: StScan only once a scan-mode cycle has been seen while enabled.
    typedef enum logic {StDirect, StScan} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  idx_q, idx_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [W-1:0]  onehot_q, onehot_d;
    logic          wrap_q, wrap_d;

    // State register; synchronous reset has priority over every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StDirect;
            idx_q    <= '0;
            pcnt_q   <= '0;
            onehot_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pcnt_q   <= pcnt_d;
            onehot_q <= onehot_d;
            wrap_q   <= wrap_d;
        end
    end

    // Next-state: decode/scan stepping; en=0 freezes idx, pcnt and mode, and blanks y.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pcnt_d  = pcnt_q;
        wrap_d  = 1'b0;

        if (bus.en) begin
            state_d = bus.mode ? StScan : StDirect;
            if (!bus.mode) begin
                idx_d  = bus.a;
                pcnt_d = '0;
            end else if (state_q == StDirect) begin
                // Mode entry: keep the last direct index, restart the dwell timer.
                pcnt_d = '0;
            end else if (bus.load) begin
                idx_d  = bus.a;
                pcnt_d = '0;
            end else if (pcnt_q == PcntLast) begin
                pcnt_d = '0;
                idx_d  = idx_q + N'(1);
                wrap_d = (idx_q == {N{1'b1}});
            end else begin
                pcnt_d = pcnt_q + PW'(1);
            end
        end
    end

    // Output strobe tracks the next index, so y is one-hot(idx) whenever enabled.
    always_comb begin
        onehot_d = '0;
        if (bus.en) begin
            onehot_d[idx_d] = 1'b1;
        end
    end

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    assign bus.y = ~onehot_q;
`else
    assign bus.y = onehot_q;
`endif
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule

// File: doc/decoder_scan_nbit.md
Name: decoder_scan_nbit

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with enable and two modes.
- Direct mode decodes an input select. Scan mode auto-steps a one-hot output through all 2^N lines at a programmable rate, e.g. for multiplexed display digit/row strobing.
- Sits between control logic and multiplexed output drivers; replaces fixed 2-to-4 combinational decoding where a registered, scanning strobe is needed.

Parameters:
- N, 2, select width; output width is 2^N; legal range 1..6.
- SCAN_DIV, 4, clock cycles per scan step; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  enable; low blanks output and freezes all state
- mode  input  1  0 = direct decode, 1 = auto-scan
- a  input  N  select value; direct-mode source, scan-mode load value
- load  input  1  scan mode only: force index to a, restart step timer
- y  output  2^N  one-hot decoded strobe, registered
- idx  output  N  current index, registered; y always equals one-hot(idx) while en is high
- wrap  output  1  one-cycle pulse when scan index rolls from 2^N-1 to 0

Behaviour:
- All state is updated on the rising edge of clk. Internal state: idx register, prescaler pcnt (width clog2(SCAN_DIV), min 1), mode_q (registered mode).
- Reset (rst=1 at an edge): y=0, idx=0, pcnt=0, wrap=0, mode_q=0. Reset has priority over all inputs, including mid-scan.
- en=0: y<=0, wrap<=0; idx, pcnt and mode_q hold.
- Direct mode (en=1, mode=0): idx<=a, y<=one-hot(a), pcnt<=0, wrap<=0. Latency is 1 cycle from a to y. load is ignored.
- Mode entry: on the first enabled cycle with mode=1 and mode_q=0, pcnt<=0, and idx and y hold the last direct value. Scanning starts from that index.
- Scan mode (en=1, mode=1, mode_q=1):
  - load=1: idx<=a, y<=one-hot(a), pcnt<=0, wrap<=0. load has priority over a step on the same cycle.
  - Otherwise, if pcnt==SCAN_DIV-1: pcnt<=0, idx<=idx+1 modulo 2^N, y<=one-hot(idx+1). wrap<=1 only when idx==2^N-1.
  - Otherwise: pcnt<=pcnt+1, idx and y hold, wrap<=0.
- Each index is therefore held for exactly SCAN_DIV enabled cycles. SCAN_DIV=1 steps every cycle.
- Leaving scan mode: the next enabled cycle is a normal direct decode of a.
- mode_q updates only on enabled cycles.
- y is never multi-hot. It is all-zero only after reset or while en=0.
- Re-enable (en 0->1): y<=one-hot(idx) on that first edge. Scan timing resumes from the frozen pcnt.

Optional Feature:
- Macro: DECODER_SCAN_ACTIVE_LOW_EN.
- Defined: y port is the bitwise inverse of the internal one-hot vector. Reset/blank value is all-ones; the active line is 0. This suits common-anode drivers.
- Not defined: y is active-high as described above.
- idx and wrap are unaffected either way.

Test Plan (N=2, SCAN_DIV=4, macro undefined unless stated):
- rst=1 for 2 cycles, then release with en=0 -> y=4'b0000, idx=0, wrap=0. Set en=1, mode=0, a=2'b10 -> y=4'b0100 exactly 1 cycle later.
- Direct mode, sweep a=0,1,2,3 on consecutive cycles -> y=0001,0010,0100,1000 each one cycle delayed. load pulses have no effect.
- Direct a=3, then mode=1 -> y=1000 held 4 cycles, then 0001 with wrap=1 for one cycle. Then 0010 after 4 more cycles; wrap stays 0.
- Scan mode: load=1 with a=2 on the same cycle pcnt==3 -> y=0100, no step, no wrap. Next step occurs 4 cycles later to 1000.
- Mid-scan: en=0 for 5 cycles -> y=0000 and idx frozen. Re-enable -> previous one-hot restored and remaining dwell continues. rst=1 mid-scan -> y=0000, idx=0 on the next edge.
- Rebuild with DECODER_SCAN_ACTIVE_LOW_EN, repeat the a=2 direct case -> y=1011. After reset -> y=1111.
